// File: rtl/dist_pkg.sv
// Shared types and arithmetic helpers for the multimode AXIS distortion block.
package dist_pkg;

    localparam int unsigned GAIN_FRAC_W = 4;
    localparam int unsigned CALC_W      = 64;

    typedef logic signed [CALC_W-1:0] calc_t;

    typedef enum logic [1:0] {
        DIST_BYPASS = 2'd0,
        DIST_HARD   = 2'd1,
        DIST_FOLD   = 2'd2,
        DIST_SOFT   = 2'd3
    } dist_mode_e;

    // Saturate x to the signed full-scale range of a w-bit two's complement value.
    function automatic calc_t sat_signed(input calc_t x, input int unsigned w);
        calc_t hi;
        calc_t lo;
        hi = (calc_t'(1) <<< (w - 1)) - calc_t'(1);
        lo = -hi - calc_t'(1);
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    // Clamp x into the symmetric window [-t, +t]; t is non-negative.
    function automatic calc_t clamp_sym(input calc_t x, input calc_t t);
        if (x > t) begin
            return t;
        end
        if (x < -t) begin
            return -t;
        end
        return x;
    endfunction

endpackage

// File: rtl/dist_shaper.sv
// Combinational stage-2 waveshaper: hard clip, fold-back and soft knee.
// Soft knee for mode 3 exists only when DIST_SOFTCLIP_EN is defined; otherwise mode 3 is a hard clip.
module dist_shaper
    import dist_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 24
) (
    input  logic signed [SAMPLE_W-1:0] i_p,
    input  logic        [SAMPLE_W-2:0] i_thr,
    input  dist_mode_e                 i_mode,
    output logic signed [SAMPLE_W-1:0] o_out_c,
    output logic                       o_mod_c
);

    calc_t w_p;
    calc_t w_t;
    calc_t w_mag;
    calc_t w_res;
    logic  w_mod;

    always_comb begin
        w_p   = calc_t'(i_p);
        w_t   = calc_t'(i_thr);
        w_mag = (w_p < 0) ? -w_p : w_p;
        w_res = w_p;
        w_mod = 1'b0;
        case (i_mode)
            DIST_HARD: begin
                w_res = clamp_sym(w_p, w_t);
                w_mod = (w_mag > w_t);
            end
            DIST_FOLD: begin
                // Reflect about the threshold, then clamp what still overshoots (large p or T=0).
                if (w_p > w_t) begin
                    w_res = (w_t <<< 1) - w_p;
                end else if (w_p < -w_t) begin
                    w_res = -(w_t <<< 1) - w_p;
                end
                w_res = clamp_sym(w_res, w_t);
                w_mod = (w_mag > w_t);
            end
            DIST_SOFT: begin
`ifdef DIST_SOFTCLIP_EN
                calc_t v_half;
                calc_t v_knee;
                v_half = w_t >>> 1;
                v_knee = v_half + ((w_mag - v_half) >>> 1);
                if (v_knee > w_t) begin
                    v_knee = w_t;
                end
                if (w_mag > v_half) begin
                    w_res = (w_p < 0) ? -v_knee : v_knee;
                    w_mod = 1'b1;
                end
`else
                w_res = clamp_sym(w_p, w_t);
                w_mod = (w_mag > w_t);
`endif
            end
            default: begin
                w_res = w_p;
                w_mod = 1'b0;
            end
        endcase
        o_out_c = SAMPLE_W'(w_res);
        o_mod_c = w_mod;
    end

endmodule

// File: rtl/axis_multimode_distortion.sv
// Two-stage AXI-Stream distortion pipeline with per-beat captured controls and a clip counter.
// Optional soft-knee mode 3 is enabled by defining DIST_SOFTCLIP_EN.
module axis_multimode_distortion
    import dist_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned SAMPLE_W = 24,
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned GAIN_W   = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                distortion_enable,
    input  logic [1:0]          mode,
    input  logic [GAIN_W-1:0]   gain,
    input  logic [SAMPLE_W-2:0] threshold,
    input  logic [NUM_CH-1:0]   ch_enable,
    input  logic                clip_clear,
    input  logic [DATA_W-1:0]   s_axis_data,
    input  logic                s_axis_valid,
    input  logic                s_axis_last,
    output logic                s_axis_ready,
    output logic [DATA_W-1:0]   m_axis_data,
    output logic                m_axis_valid,
    output logic                m_axis_last,
    input  logic                m_axis_ready,
    output logic [CNT_W-1:0]    clip_count
);

    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PROD_W = SAMPLE_W + GAIN_W + 1;

    logic                       w_adv;
    logic                       w_accept;
    logic                       w_fx;
    logic signed [SAMPLE_W-1:0] w_sample;
    logic signed [PROD_W-1:0]   w_prod;
    logic signed [SAMPLE_W-1:0] w_p;
    logic signed [SAMPLE_W-1:0] w_shaped;
    logic                       w_mod;

    logic [CH_W-1:0]            r_ch;
    logic                       r_s1_valid;
    logic                       r_s1_last;
    logic                       r_s1_fx;
    logic [DATA_W-1:0]          r_s1_word;
    logic signed [SAMPLE_W-1:0] r_s1_p;
    logic [SAMPLE_W-2:0]        r_s1_thr;
    dist_mode_e                 r_s1_mode;

    logic                       r_m_valid;
    logic                       r_m_last;
    logic [DATA_W-1:0]          r_m_data;
    logic                       r_m_mod;
    logic [CNT_W-1:0]           r_clip_cnt;

    assign w_adv        = !r_m_valid || m_axis_ready;
    assign s_axis_ready = w_adv;
    assign w_accept     = s_axis_valid && w_adv;

    // Stage-1 arithmetic: Q.4 pre-gain with saturation back to sample full scale.
    assign w_sample = s_axis_data[SAMPLE_W-1:0];
    assign w_prod   = PROD_W'(w_sample) * PROD_W'($signed({1'b0, gain}));
    assign w_p      = SAMPLE_W'(sat_signed(calc_t'(w_prod >>> GAIN_FRAC_W), SAMPLE_W));
    assign w_fx     = distortion_enable && ch_enable[r_ch] && (mode != 2'd0);

    // Channel position within the interleaved frame; a packet end realigns to channel 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ch <= '0;
        end else if (w_accept) begin
            if (s_axis_last || (r_ch == CH_W'(NUM_CH - 1))) begin
                r_ch <= '0;
            end else begin
                r_ch <= r_ch + CH_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_fx    <= 1'b0;
            r_s1_word  <= '0;
            r_s1_p     <= '0;
            r_s1_thr   <= '0;
            r_s1_mode  <= DIST_BYPASS;
        end else if (w_adv) begin
            r_s1_valid <= s_axis_valid;
            r_s1_last  <= s_axis_last;
            r_s1_fx    <= w_fx;
            r_s1_word  <= s_axis_data;
            r_s1_p     <= w_p;
            r_s1_thr   <= threshold;
            r_s1_mode  <= dist_mode_e'(mode);
        end
    end

    dist_shaper #(
        .SAMPLE_W (SAMPLE_W)
    ) u_shaper (
        .i_p     (r_s1_p),
        .i_thr   (r_s1_thr),
        .i_mode  (r_s1_mode),
        .o_out_c (w_shaped),
        .o_mod_c (w_mod)
    );

    // Output stage; holds steady whenever the downstream stalls.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= '0;
            r_m_mod   <= 1'b0;
        end else if (w_adv) begin
            r_m_valid <= r_s1_valid;
            r_m_last  <= r_s1_last;
            r_m_data  <= r_s1_fx ? {r_s1_word[DATA_W-1:SAMPLE_W], w_shaped} : r_s1_word;
            r_m_mod   <= r_s1_valid && r_s1_fx && w_mod;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_clip_cnt <= '0;
        end else if (clip_clear) begin
            r_clip_cnt <= '0;
        end else if (r_m_valid && m_axis_ready && r_m_mod && (r_clip_cnt != {CNT_W{1'b1}})) begin
            r_clip_cnt <= r_clip_cnt + CNT_W'(1);
        end
    end

    assign m_axis_valid = r_m_valid;
    assign m_axis_last  = r_m_last;
    assign m_axis_data  = r_m_data;
    assign clip_count   = r_clip_cnt;

endmodule

// File: tb/tb_axis_multimode_distortion.sv
// Scoreboard bench for axis_multimode_distortion (default build, soft knee disabled).
module tb_axis_multimode_distortion;

    logic        clk;
    logic        resetn;
    logic        distortion_enable;
    logic [1:0]  mode;
    logic [7:0]  gain;
    logic [22:0] threshold;
    logic [1:0]  ch_enable;
    logic        clip_clear;
    logic [31:0] s_axis_data;
    logic        s_axis_valid;
    logic        s_axis_last;
    logic        s_axis_ready;
    logic [31:0] m_axis_data;
    logic        m_axis_valid;
    logic        m_axis_last;
    logic        m_axis_ready;
    logic [15:0] clip_count;

    axis_multimode_distortion dut (
        .clk               (clk),
        .resetn            (resetn),
        .distortion_enable (distortion_enable),
        .mode              (mode),
        .gain              (gain),
        .threshold         (threshold),
        .ch_enable         (ch_enable),
        .clip_clear        (clip_clear),
        .s_axis_data       (s_axis_data),
        .s_axis_valid      (s_axis_valid),
        .s_axis_last       (s_axis_last),
        .s_axis_ready      (s_axis_ready),
        .m_axis_data       (m_axis_data),
        .m_axis_valid      (m_axis_valid),
        .m_axis_last       (m_axis_last),
        .m_axis_ready      (m_axis_ready),
        .clip_count        (clip_count)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        bit          mod;
    } exp_t;

    exp_t q[$];
    int   errors    = 0;
    int   checks    = 0;
    int   tb_ch     = 0;
    int   exp_clip  = 0;
    bit   rnd_ready = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model using the current control inputs.
    function automatic void model(input logic [31:0] w, input int chn,
                                  output logic [31:0] o, output bit m);
        longint s, p, t, r, mag;
        o = w;
        m = 0;
        if (!distortion_enable || !ch_enable[chn] || mode == 2'd0) return;
        s = longint'($signed(w[23:0]));
        p = (s * longint'(gain)) >>> 4;
        if (p > 8388607) p = 8388607;
        if (p < -8388608) p = -8388608;
        t   = longint'(threshold);
        mag = (p < 0) ? -p : p;
        r   = p;
        if (mode == 2'd2) begin
            if (p > t) r = 2 * t - p;
            else if (p < -t) r = -2 * t - p;
        end
        if (r > t) r = t;
        if (r < -t) r = -t;
        m = (mag > t);
        o = {w[31:24], r[23:0]};
    endfunction

    task automatic send(input logic [31:0] w, input logic l);
        exp_t e;
        bit   acc;
        model(w, tb_ch, e.data, e.mod);
        e.last       = l;
        s_axis_valid = 1'b1;
        s_axis_data  = w;
        s_axis_last  = l;
        acc = 0;
        for (int k = 0; k < 500 && !acc; k++) begin
            @(negedge clk);
            acc = s_axis_ready;
            @(posedge clk);
            #1;
        end
        s_axis_valid = 1'b0;
        if (acc) begin
            q.push_back(e);
            tb_ch = l ? 0 : (tb_ch + 1) % 2;
        end else begin
            check("send_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 2000; k++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        if (q.size() != 0) begin
            check("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic de, input logic [1:0] md, input logic [7:0] gn,
                           input logic [22:0] th, input logic [1:0] che);
        distortion_enable = de;
        mode              = md;
        gain              = gn;
        threshold         = th;
        ch_enable         = che;
    endtask

    // Downstream ready: always high, or random ~60% high during the stress phase.
    initial begin
        m_axis_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_ready = rnd_ready ? ($urandom_range(0, 99) >= 40) : 1'b1;
        end
    end

    // Output monitor: pops the scoreboard on each handshake and checks stall stability.
    initial begin
        exp_t        e;
        bit          stall;
        logic [31:0] hold_d;
        logic        hold_l;
        stall  = 0;
        hold_d = '0;
        hold_l = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                stall = 0;
                continue;
            end
            if (stall && m_axis_valid) begin
                check("stall_data", m_axis_data, hold_d);
                check("stall_last", 32'(m_axis_last), 32'(hold_l));
            end
            if (m_axis_valid && m_axis_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("out_data", m_axis_data, e.data);
                    check("out_last", 32'(m_axis_last), 32'(e.last));
                    if (e.mod && exp_clip < 65535) exp_clip++;
                end
            end
            stall  = m_axis_valid && !m_axis_ready;
            hold_d = m_axis_data;
            hold_l = m_axis_last;
        end
    end

    initial begin
        resetn       = 1'b0;
        s_axis_valid = 1'b0;
        s_axis_data  = '0;
        s_axis_last  = 1'b0;
        clip_clear   = 1'b0;
        set_cfg(1'b0, 2'd0, 8'h10, 23'd0, 2'b11);

        #12;
        check("rst_m_valid", 32'(m_axis_valid), 32'd0);
        check("rst_m_last", 32'(m_axis_last), 32'd0);
        check("rst_m_data", m_axis_data, 32'd0);
        check("rst_clip", 32'(clip_count), 32'd0);
        check("rst_s_ready", 32'(s_axis_ready), 32'd1);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Hard clip at unity gain
        set_cfg(1'b1, 2'd1, 8'h10, 23'h400000, 2'b11);
        send(32'hAB500000, 1'b0);
        send(32'h00A00000, 1'b0);
        send(32'h00123456, 1'b1);
        drain();
        check("clip_hard", 32'(clip_count), 32'd2);

        clip_clear = 1'b1;
        @(posedge clk);
        #1;
        clip_clear = 1'b0;
        exp_clip   = 0;
        check("clip_clear", 32'(clip_count), 32'd0);

        // Gain above and below unity
        gain = 8'h20;
        send(32'h00300000, 1'b1);
        gain = 8'h08;
        send(32'h00300000, 1'b1);
        drain();
        check("clip_gain", 32'(clip_count), 32'(exp_clip));

        // Fold-back
        set_cfg(1'b1, 2'd2, 8'h10, 23'h400000, 2'b11);
        send(32'h00500000, 1'b0);
        send(32'h007FFFFF, 1'b0);
        send(32'h00B00000, 1'b1);
        drain();
        check("clip_fold", 32'(clip_count), 32'(exp_clip));

        // Zero threshold, passthrough, bypass and mode 3 as hard clip
        set_cfg(1'b1, 2'd1, 8'h10, 23'd0, 2'b11);
        send(32'h00123456, 1'b0);
        send(32'h55FFF000, 1'b1);
        mode = 2'd2;
        send(32'h00000001, 1'b1);
        set_cfg(1'b0, 2'd1, 8'h40, 23'h000100, 2'b11);
        send(32'hFF7FFFFF, 1'b1);
        set_cfg(1'b1, 2'd0, 8'h40, 23'h000100, 2'b11);
        send(32'h12345678, 1'b1);
        set_cfg(1'b1, 2'd3, 8'h10, 23'h400000, 2'b11);
        send(32'h00500000, 1'b1);
        drain();
        check("clip_misc", 32'(clip_count), 32'(exp_clip));

        // Per-channel enable across a 6-beat packet, then a new packet on channel 0
        set_cfg(1'b1, 2'd1, 8'h10, 23'h400000, 2'b01);
        for (int i = 0; i < 6; i++) send(32'h00500000, (i == 5));
        send(32'h00500000, 1'b1);
        drain();
        check("clip_chan", 32'(clip_count), 32'(exp_clip));

        // Latency of two clocks, and clear winning over a same-cycle increment
        set_cfg(1'b1, 2'd1, 8'h10, 23'h400000, 2'b11);
        send(32'h00500000, 1'b1);
        check("latency_early", 32'(m_axis_valid), 32'd0);
        @(posedge clk);
        #1;
        check("latency_2clk", 32'(m_axis_valid), 32'd1);
        clip_clear = 1'b1;
        @(posedge clk);
        #1;
        clip_clear = 1'b0;
        exp_clip   = 0;
        check("clear_wins", 32'(clip_count), 32'd0);
        drain();

        // Random stream with random backpressure and per-beat controls
        rnd_ready = 1;
        for (int i = 0; i < 100; i++) begin
            set_cfg(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                    8'($urandom_range(0, 255)), 23'($urandom), 2'($urandom_range(0, 3)));
            send($urandom, ($urandom_range(0, 7) == 0));
        end
        drain();
        rnd_ready = 0;
        drain();
        check("clip_random", 32'(clip_count), 32'(exp_clip));

        // Asynchronous reset with beats in flight
        set_cfg(1'b1, 2'd1, 8'h10, 23'h400000, 2'b01);
        send(32'h00000001, 1'b1);
        send(32'h00500000, 1'b0);
        send(32'h00500000, 1'b0);
        send(32'h00500000, 1'b0);
        check("inflight_valid", 32'(m_axis_valid), 32'd1);
        resetn = 1'b0;
        #1;
        check("async_rst_valid", 32'(m_axis_valid), 32'd0);
        check("async_rst_clip", 32'(clip_count), 32'd0);
        q.delete();
        tb_ch    = 0;
        exp_clip = 0;
        @(posedge clk);
        #3;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        send(32'h00500000, 1'b1);
        drain();
        check("post_rst_clip", 32'(clip_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_multimode_distortion.md
AXIS_MULTIMODE_DISTORTION -- requirements
Module: axis_multimode_distortion

Interface
REQ-001 Parameter DATA_W, default 32: AXIS word width.
REQ-002 Parameter SAMPLE_W, default 24: signed sample field, bits [SAMPLE_W-1:0] of each word.
REQ-003 Parameter NUM_CH, default 2: interleaved channels per frame.
REQ-004 Parameter GAIN_W, default 8: unsigned pre-gain, Q(GAIN_W-4).4.
REQ-005 Parameter CNT_W, default 16: clip-counter width.
REQ-006 Ports, in this order:
- clk  in  1  sole clock.
- resetn  in  1  reset; asynchronous, active-low.
- distortion_enable  in  1  global enable; 0 = bit-exact passthrough.
- mode  in  2  0 bypass, 1 hard clip, 2 fold-back, 3 soft clip.
- gain  in  GAIN_W  pre-gain; 0x10 = 1.0.
- threshold  in  SAMPLE_W-1  unsigned magnitude T; clip window [-T,+T].
- ch_enable  in  NUM_CH  per-channel effect enable.
- clip_clear  in  1  synchronous clear of clip_count.
- s_axis_data/valid/last  in  DATA_W/1/1; s_axis_ready  out  1.
- m_axis_data/valid/last  out  DATA_W/1/1; m_axis_ready  in  1.
- clip_count  out  CNT_W  saturating count of modified samples.

Function
REQ-007 Two-stage valid/ready pipeline; adv = !m_axis_valid || m_axis_ready; s_axis_ready = adv (combinational); all stages shift only when adv is 1.
REQ-008 Latency exactly 2 clk from accepted input beat to m_axis_valid under no backpressure; throughput 1 beat/clk.
REQ-009 No beat lost, duplicated or reordered under any m_axis_ready pattern; m_axis_data/last held stable while valid && !ready.
REQ-010 mode, gain, threshold, ch_enable and distortion_enable are captured with each beat at acceptance and travel with it; changes affect only later beats.
REQ-011 Channel counter ch: increments on each accepted beat, wraps NUM_CH-1 -> 0, and is forced to 0 after a beat with s_axis_last=1.
REQ-012 Effect applies only if distortion_enable && ch_enable[ch] && mode != 0; otherwise the output word equals the input word.
REQ-013 Stage 1: p = sample * gain, arithmetic shift right 4, saturated to signed SAMPLE_W full scale.
REQ-014 Stage 2, mode 1: out = clamp(p, -T, +T).
REQ-015 Stage 2, mode 2: if p > T then out = 2T - p; if p < -T then out = -2T - p; result then clamped to [-T, +T].
REQ-016 Stage 2, mode 3: see REQ-023/024.
REQ-017 Output word = {input[DATA_W-1:SAMPLE_W], out}; m_axis_last is the captured s_axis_last of the same beat.
REQ-018 T = 0: every effected sample outputs 0.
REQ-019 clip_count +1 per output handshake whose sample was modified by stage 2 (|p| > T or soft knee engaged); saturates at all-ones.
REQ-020 clip_clear and an increment in the same cycle: clear wins; count = 0.

Reset
REQ-021 resetn low asynchronously clears both stage valids, m_axis_valid, m_axis_last, m_axis_data, ch and clip_count to 0; s_axis_ready reads 1 once valids are 0.
REQ-022 Reset mid-packet discards in-flight beats; the first beat after release is treated as channel 0.

Configuration
REQ-023 Macro DIST_SOFTCLIP_EN defined: mode 3 = soft knee; |p| <= T/2 passes; above, out = sign(p)*(T/2 + (|p|-T/2)/2), clamped to T.
REQ-024 Macro DIST_SOFTCLIP_EN undefined: mode 3 behaves identically to mode 1; no soft-knee logic is synthesised.

Structure
REQ-025 Package dist_pkg holds the mode enum (DIST_BYPASS, DIST_HARD, DIST_FOLD, DIST_SOFT), the gain fraction-bit constant (4) and the saturate/clamp functions.
REQ-026 One sub-module, dist_shaper: combinational stage-2 shaping of p, T and mode to out and a modified flag.

Verification
REQ-027 SAMPLE_W=24, gain=0x10, T=0x400000, mode 1: 0x500000 -> 0x400000; 0xA00000 -> 0xC00000; 0x123456 -> 0x123456; clip_count=2.
REQ-028 gain=0x20, mode 1: 0x300000 -> 0x400000; gain=0x08: 0x300000 -> 0x180000, not counted.
REQ-029 mode 2, T=0x400000: 0x500000 -> 0x300000; 0x7FFFFF -> 0x000001; 0xB00000 -> 0xD00000.
REQ-030 NUM_CH=2, ch_enable=2'b01, mode 1, 6-beat packet of 0x500000 with last on beat 5: even beats -> 0x400000, odd beats unchanged; next packet starts at ch 0.
REQ-031 100-beat random stream with m_axis_ready randomly low ~40% of cycles: output sequence matches the reference model; data stable during stalls.
REQ-032 resetn asserted with 2 beats in flight: m_axis_valid drops in the same cycle without a clock edge; after release 0x500000 -> 0x400000 as channel 0.
